// File: rtl/cci_mpf_shim_edge_fiu_rd_inject.sv
// rtl/cci_mpf_shim_edge_fiu_rd_inject.sv - merges internal client line reads into the AFU c0 read stream at the FIU edge
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   afu_rd_valid/addr/mdata, deq    AFU read FIFO head; deq is combinational
//   fiu_alm_full                    FIU c0 almost full (blocks all issue)
//   fiu_rd_valid/addr/mdata         registered read request to FIU
//   fiu_rsp_valid/mdata/data        FIU read response
//   afu_rsp_valid/mdata/data        registered response for AFU-originated reads
//   cl_req_en/addr, cl_req_rdy      per-client read request handshake
//   cl_rsp_en, cl_rsp_data          registered one-hot client response strobe, shared data
//   err                             sticky: [0] AFU used reserved Mdata bit, [1] orphan internal response
module cci_mpf_shim_edge_fiu_rd_inject #(
  parameter int N_CLIENTS        = 2,
  parameter int ADDR_WIDTH       = 42,
  parameter int MDATA_WIDTH      = 16,
  parameter int DATA_WIDTH       = 512,
  parameter int RSV_MDATA_IDX    = 15,
  parameter int MAX_INJECT_BURST = 4,
  parameter int MAX_OUTSTANDING  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            afu_rd_valid,
  input  logic [ADDR_WIDTH-1:0]           afu_rd_addr,
  input  logic [MDATA_WIDTH-1:0]          afu_rd_mdata,
  output logic                            afu_rd_deq,
  input  logic                            fiu_alm_full,
  output logic                            fiu_rd_valid,
  output logic [ADDR_WIDTH-1:0]           fiu_rd_addr,
  output logic [MDATA_WIDTH-1:0]          fiu_rd_mdata,
  input  logic                            fiu_rsp_valid,
  input  logic [MDATA_WIDTH-1:0]          fiu_rsp_mdata,
  input  logic [DATA_WIDTH-1:0]           fiu_rsp_data,
  output logic                            afu_rsp_valid,
  output logic [MDATA_WIDTH-1:0]          afu_rsp_mdata,
  output logic [DATA_WIDTH-1:0]           afu_rsp_data,
  input  logic [N_CLIENTS-1:0]            cl_req_en,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0] cl_req_addr,
  output logic [N_CLIENTS-1:0]            cl_req_rdy,
  output logic [N_CLIENTS-1:0]            cl_rsp_en,
  output logic [DATA_WIDTH-1:0]           cl_rsp_data,
  output logic [1:0]                      err
);

  localparam int CID_W   = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int BURST_W = $clog2(MAX_INJECT_BURST + 1);

  logic [N_CLIENTS-1:0]   pending;
  logic [ADDR_WIDTH-1:0]  pend_addr [N_CLIENTS];
  logic [CNT_W-1:0]       cnt [N_CLIENTS];
  logic [BURST_W-1:0]     burst_cnt;
  logic [CID_W-1:0]       rr_ptr;

  logic                   any_pending;
  logic                   inject;
  logic [CID_W-1:0]       win_id;
  logic [CID_W-1:0]       id_hi;
  logic [CID_W-1:0]       id_lo;
  logic                   win_hi;
  logic [ADDR_WIDTH-1:0]  inj_addr;
  logic [MDATA_WIDTH-1:0] inj_mdata;
  logic [N_CLIENTS-1:0]   iss;
  logic [N_CLIENTS-1:0]   rsp_dec;
  logic                   rsp_rsv;
  logic [CID_W-1:0]       rsp_id;
  logic                   orphan;

  assign any_pending = |pending;
  assign rsp_rsv     = fiu_rsp_mdata[RSV_MDATA_IDX];
  assign rsp_id      = fiu_rsp_mdata[CID_W-1:0];

  // AFU may only be held off while the burst budget lasts.
  assign inject = !fiu_alm_full && any_pending &&
                  ((int'(burst_cnt) < MAX_INJECT_BURST) || !afu_rd_valid);
  assign afu_rd_deq = !fiu_alm_full && !inject && afu_rd_valid;

  // Round-robin pick: lowest pending index >= rr_ptr, else lowest pending
  // index overall (wrap). Descending scan so the lowest match is kept.
  always_comb begin
    id_hi  = '0;
    id_lo  = '0;
    win_hi = 1'b0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        id_lo = CID_W'(i);
        if (i >= int'(rr_ptr)) begin
          id_hi  = CID_W'(i);
          win_hi = 1'b1;
        end
      end
    end
    win_id = win_hi ? id_hi : id_lo;
  end

  always_comb begin
    inj_addr  = '0;
    inj_mdata = '0;
    inj_mdata[RSV_MDATA_IDX] = 1'b1;
    inj_mdata[CID_W-1:0]     = win_id;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (win_id == CID_W'(i)) inj_addr = pend_addr[i];
    end
  end

  // Ids beyond N_CLIENTS match no client and therefore fall out as orphans.
  always_comb begin
    iss     = '0;
    rsp_dec = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      iss[i]       = inject && (win_id == CID_W'(i));
      rsp_dec[i]   = fiu_rsp_valid && rsp_rsv && (rsp_id == CID_W'(i)) && (cnt[i] != '0);
      cl_req_rdy[i] = !pending[i] && (int'(cnt[i]) < MAX_OUTSTANDING);
    end
    orphan = fiu_rsp_valid && rsp_rsv && !(|rsp_dec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending       <= '0;
      burst_cnt     <= '0;
      rr_ptr        <= '0;
      fiu_rd_valid  <= 1'b0;
      afu_rsp_valid <= 1'b0;
      cl_rsp_en     <= '0;
      err           <= '0;
      for (int i = 0; i < N_CLIENTS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (iss[i]) pending[i] <= 1'b0;
        else if (cl_req_en[i] && cl_req_rdy[i]) pending[i] <= 1'b1;

        if (iss[i] && !rsp_dec[i]) cnt[i] <= cnt[i] + 1'b1;
        else if (rsp_dec[i] && !iss[i]) cnt[i] <= cnt[i] - 1'b1;
      end

      // Under back-pressure the burst count is frozen; otherwise any
      // non-injecting cycle (AFU forwarded or nothing pending) clears it.
      if (!fiu_alm_full) begin
        if (inject) begin
          if (int'(burst_cnt) < MAX_INJECT_BURST) burst_cnt <= burst_cnt + 1'b1;
          if (int'(win_id) == N_CLIENTS - 1) rr_ptr <= '0;
          else rr_ptr <= win_id + 1'b1;
        end else begin
          burst_cnt <= '0;
        end
      end

      fiu_rd_valid  <= inject || afu_rd_deq;
      afu_rsp_valid <= fiu_rsp_valid && !rsp_rsv;
      cl_rsp_en     <= rsp_dec;
      if (afu_rd_valid && afu_rd_mdata[RSV_MDATA_IDX]) err[0] <= 1'b1;
      if (orphan) err[1] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (cl_req_en[i] && cl_req_rdy[i]) pend_addr[i] <= cl_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
    fiu_rd_addr   <= inject ? inj_addr : afu_rd_addr;
    fiu_rd_mdata  <= inject ? inj_mdata : afu_rd_mdata;
    afu_rsp_mdata <= fiu_rsp_mdata;
    afu_rsp_data  <= fiu_rsp_data;
    cl_rsp_data   <= fiu_rsp_data;
  end

endmodule

// File: tb/tb_cci_mpf_shim_edge_fiu_rd_inject.sv
// tb/tb_cci_mpf_shim_edge_fiu_rd_inject.sv - directed self-checking bench for the FIU edge read injector
module tb_cci_mpf_shim_edge_fiu_rd_inject;

  localparam int N  = 2;
  localparam int AW = 42;
  localparam int MW = 16;
  localparam int DW = 512;

  logic            clk;
  logic            reset;
  logic            afu_rd_valid;
  logic [AW-1:0]   afu_rd_addr;
  logic [MW-1:0]   afu_rd_mdata;
  logic            afu_rd_deq;
  logic            fiu_alm_full;
  logic            fiu_rd_valid;
  logic [AW-1:0]   fiu_rd_addr;
  logic [MW-1:0]   fiu_rd_mdata;
  logic            fiu_rsp_valid;
  logic [MW-1:0]   fiu_rsp_mdata;
  logic [DW-1:0]   fiu_rsp_data;
  logic            afu_rsp_valid;
  logic [MW-1:0]   afu_rsp_mdata;
  logic [DW-1:0]   afu_rsp_data;
  logic [N-1:0]    cl_req_en;
  logic [N*AW-1:0] cl_req_addr;
  logic [N-1:0]    cl_req_rdy;
  logic [N-1:0]    cl_rsp_en;
  logic [DW-1:0]   cl_rsp_data;
  logic [1:0]      err;

  int n_cmp = 0;
  int n_err = 0;
  logic         loopback;
  logic         auto_req;
  logic [N-1:0] auto_mask;

  cci_mpf_shim_edge_fiu_rd_inject #(
    .N_CLIENTS(N), .ADDR_WIDTH(AW), .MDATA_WIDTH(MW), .DATA_WIDTH(DW),
    .RSV_MDATA_IDX(15), .MAX_INJECT_BURST(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .reset(reset),
    .afu_rd_valid(afu_rd_valid), .afu_rd_addr(afu_rd_addr), .afu_rd_mdata(afu_rd_mdata),
    .afu_rd_deq(afu_rd_deq), .fiu_alm_full(fiu_alm_full),
    .fiu_rd_valid(fiu_rd_valid), .fiu_rd_addr(fiu_rd_addr), .fiu_rd_mdata(fiu_rd_mdata),
    .fiu_rsp_valid(fiu_rsp_valid), .fiu_rsp_mdata(fiu_rsp_mdata), .fiu_rsp_data(fiu_rsp_data),
    .afu_rsp_valid(afu_rsp_valid), .afu_rsp_mdata(afu_rsp_mdata), .afu_rsp_data(afu_rsp_data),
    .cl_req_en(cl_req_en), .cl_req_addr(cl_req_addr), .cl_req_rdy(cl_req_rdy),
    .cl_rsp_en(cl_rsp_en), .cl_rsp_data(cl_rsp_data), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge; optionally
  // echo the issued request back as a response and re-request when ready.
  task automatic tick();
    @(posedge clk);
    #1;
    if (loopback) begin
      fiu_rsp_valid = fiu_rd_valid;
      fiu_rsp_mdata = fiu_rd_mdata;
    end
    if (auto_req) cl_req_en = cl_req_rdy & auto_mask;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    loopback      = 1'b0;
    auto_req      = 1'b0;
    auto_mask     = '0;
    afu_rd_valid  = 1'b0;
    afu_rd_addr   = '0;
    afu_rd_mdata  = '0;
    fiu_alm_full  = 1'b0;
    fiu_rsp_valid = 1'b0;
    fiu_rsp_mdata = '0;
    fiu_rsp_data  = '0;
    cl_req_en     = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int deq_cnt;
    int inj_n;
    logic seen_v;
    logic seen_d;
    logic [15:0] exp_md;

    cl_req_addr = '0;
    do_reset();

    // Reset state
    chk("rst_fiu_rd_valid", 64'(fiu_rd_valid), 64'h0);
    chk("rst_afu_rsp_valid", 64'(afu_rsp_valid), 64'h0);
    chk("rst_cl_rsp_en", 64'(cl_rsp_en), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_cl_req_rdy", 64'(cl_req_rdy), 64'h3);
    chk("rst_afu_rd_deq", 64'(afu_rd_deq), 64'h0);

    // Single client issue and response
    cl_req_addr[0 +: AW] = 42'h1000;
    cl_req_en = 2'b01;
    tick();
    cl_req_en = 2'b00;
    chk("t1_rdy_busy", 64'(cl_req_rdy), 64'h2);
    chk("t1_no_issue_yet", 64'(fiu_rd_valid), 64'h0);
    tick();
    chk("t1_issue_valid", 64'(fiu_rd_valid), 64'h1);
    chk("t1_issue_addr", 64'(fiu_rd_addr), 64'h1000);
    chk("t1_issue_mdata", 64'(fiu_rd_mdata), 64'h8000);
    chk("t1_rdy_back", 64'(cl_req_rdy), 64'h3);
    fiu_rsp_valid = 1'b1;
    fiu_rsp_mdata = 16'h8000;
    fiu_rsp_data  = 512'hABCD;
    tick();
    fiu_rsp_valid = 1'b0;
    chk("t1_cl_rsp_en", 64'(cl_rsp_en), 64'h1);
    chk("t1_cl_rsp_data", cl_rsp_data[63:0], 64'hABCD);
    chk("t1_no_afu_rsp", 64'(afu_rsp_valid), 64'h0);
    chk("t1_err", 64'(err), 64'h0);
    tick();
    chk("t1_cl_rsp_en_drop", 64'(cl_rsp_en), 64'h0);

    // Round-robin between two continuously requesting clients
    do_reset();
    cl_req_addr[0 +: AW]  = 42'h2000;
    cl_req_addr[AW +: AW] = 42'h3000;
    loopback  = 1'b1;
    auto_mask = 2'b11;
    auto_req  = 1'b1;
    cl_req_en = 2'b11;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_md = (k % 2 == 1) ? 16'h8001 : 16'h8000;
      chk("t2_rr_valid", 64'(fiu_rd_valid), 64'h1);
      chk("t2_rr_mdata", 64'(fiu_rd_mdata), 64'(exp_md));
      chk("t2_rr_addr", 64'(fiu_rd_addr), (k % 2 == 1) ? 64'h3000 : 64'h2000);
      if (k >= 1) chk("t2_rr_rsp_en", 64'(cl_rsp_en), (k % 2 == 1) ? 64'h1 : 64'h2);
    end

    // AFU starvation protection: 4 injections then one AFU read
    do_reset();
    cl_req_addr[0 +: AW]  = 42'h2000;
    cl_req_addr[AW +: AW] = 42'h3000;
    afu_rd_addr  = 42'h5000;
    afu_rd_mdata = 16'h0042;
    fiu_rsp_data = 512'h55;
    loopback  = 1'b1;
    auto_mask = 2'b11;
    auto_req  = 1'b1;
    cl_req_en = 2'b11;
    tick();
    afu_rd_valid = 1'b1;
    deq_cnt = 0;
    inj_n   = 0;
    for (int k = 1; k <= 10; k++) begin
      deq_cnt += int'(afu_rd_deq);
      tick();
      chk("t3_valid", 64'(fiu_rd_valid), 64'h1);
      if (k % 5 == 0) begin
        chk("t3_afu_mdata", 64'(fiu_rd_mdata), 64'h0042);
        chk("t3_afu_addr", 64'(fiu_rd_addr), 64'h5000);
      end else begin
        exp_md = (inj_n % 2 == 1) ? 16'h8001 : 16'h8000;
        chk("t3_inj_mdata", 64'(fiu_rd_mdata), 64'(exp_md));
        inj_n++;
      end
      if (k == 6) begin
        chk("t3_afu_rsp_valid", 64'(afu_rsp_valid), 64'h1);
        chk("t3_afu_rsp_mdata", 64'(afu_rsp_mdata), 64'h0042);
        chk("t3_afu_rsp_data", afu_rsp_data[63:0], 64'h55);
      end
    end
    chk("t3_deq_count", 64'(deq_cnt), 64'd2);
    chk("t3_err", 64'(err), 64'h0);

    // Outstanding limit and simultaneous issue/response
    do_reset();
    cl_req_addr[0 +: AW] = 42'h4000;
    cl_req_en = 2'b01;
    tick();
    cl_req_en = 2'b00;
    tick();
    chk("t4_rdy_after_one", 64'(cl_req_rdy), 64'h3);
    cl_req_en = 2'b01;
    tick();
    cl_req_en = 2'b00;
    tick();
    chk("t4_second_issue", 64'(fiu_rd_valid), 64'h1);
    chk("t4_rdy_at_limit", 64'(cl_req_rdy), 64'h2);
    fiu_rsp_valid = 1'b1;
    fiu_rsp_mdata = 16'h8000;
    tick();
    fiu_rsp_valid = 1'b0;
    chk("t4_rsp_en", 64'(cl_rsp_en), 64'h1);
    chk("t4_rdy_recovered", 64'(cl_req_rdy), 64'h3);
    cl_req_en = 2'b01;
    tick();
    cl_req_en = 2'b00;
    fiu_rsp_valid = 1'b1;
    fiu_rsp_mdata = 16'h8000;
    tick();
    fiu_rsp_valid = 1'b0;
    chk("t4_same_cycle_issue", 64'(fiu_rd_valid), 64'h1);
    chk("t4_same_cycle_rsp", 64'(cl_rsp_en), 64'h1);
    chk("t4_same_cycle_rdy", 64'(cl_req_rdy), 64'h3);
    cl_req_en = 2'b01;
    tick();
    cl_req_en = 2'b00;
    tick();
    chk("t4_limit_again", 64'(cl_req_rdy), 64'h2);

    // Back-pressure
    do_reset();
    fiu_alm_full = 1'b1;
    afu_rd_valid = 1'b1;
    afu_rd_addr  = 42'h6000;
    afu_rd_mdata = 16'h0011;
    cl_req_addr[0 +: AW] = 42'h7000;
    cl_req_en = 2'b01;
    tick();
    cl_req_en = 2'b00;
    seen_v = 1'b0;
    seen_d = 1'b0;
    for (int k = 0; k < 10; k++) begin
      seen_d |= afu_rd_deq;
      tick();
      seen_v |= fiu_rd_valid;
    end
    chk("t5_no_valid", 64'(seen_v), 64'h0);
    chk("t5_no_deq", 64'(seen_d), 64'h0);
    chk("t5_still_pending", 64'(cl_req_rdy), 64'h2);
    fiu_alm_full = 1'b0;
    chk("t5_client_first_deq", 64'(afu_rd_deq), 64'h0);
    tick();
    chk("t5_client_valid", 64'(fiu_rd_valid), 64'h1);
    chk("t5_client_mdata", 64'(fiu_rd_mdata), 64'h8000);
    chk("t5_client_addr", 64'(fiu_rd_addr), 64'h7000);
    chk("t5_afu_deq", 64'(afu_rd_deq), 64'h1);
    tick();
    afu_rd_valid = 1'b0;
    chk("t5_afu_valid", 64'(fiu_rd_valid), 64'h1);
    chk("t5_afu_mdata", 64'(fiu_rd_mdata), 64'h0011);
    chk("t5_afu_addr", 64'(fiu_rd_addr), 64'h6000);

    // Error flags
    do_reset();
    afu_rd_valid = 1'b1;
    afu_rd_mdata = 16'h8000;
    afu_rd_addr  = 42'h9000;
    tick();
    afu_rd_valid = 1'b0;
    chk("t6_err0", 64'(err), 64'h1);
    chk("t6_fwd_valid", 64'(fiu_rd_valid), 64'h1);
    chk("t6_fwd_mdata", 64'(fiu_rd_mdata), 64'h8000);
    chk("t6_fwd_addr", 64'(fiu_rd_addr), 64'h9000);
    fiu_rsp_valid = 1'b1;
    fiu_rsp_mdata = 16'h8001;
    tick();
    fiu_rsp_valid = 1'b0;
    chk("t6_err1", 64'(err), 64'h3);
    chk("t6_orphan_no_rsp", 64'(cl_rsp_en), 64'h0);
    chk("t6_orphan_no_afu", 64'(afu_rsp_valid), 64'h0);
    do_reset();
    chk("t6_err_reset", 64'(err), 64'h0);
    cl_req_addr[0 +: AW] = 42'hA000;
    cl_req_en = 2'b01;
    tick();
    cl_req_en = 2'b00;
    tick();
    chk("t6_inflight_issue", 64'(fiu_rd_valid), 64'h1);
    do_reset();
    chk("t6_err_reset2", 64'(err), 64'h0);
    chk("t6_rdy_reset", 64'(cl_req_rdy), 64'h3);
    fiu_rsp_valid = 1'b1;
    fiu_rsp_mdata = 16'h8000;
    tick();
    fiu_rsp_valid = 1'b0;
    chk("t6_post_reset_orphan", 64'(err), 64'h2);
    chk("t6_post_reset_no_rsp", 64'(cl_rsp_en), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
